// File: rtl/axi_arbiter_2m1s.sv
// Two-master to one-slave AXI4 arbiter.
// Read (AR/R) and write (AW/W/B) paths are arbitrated independently with a
// round-robin grant. The grant stays locked until the transaction completes.
// Address-channel payload layout: {addr, id, len[7:0], size[2:0], burst[1:0], cache[3:0]}.
module axi_arbiter_2m1s #(
  parameter  int unsigned ADDR_W = 64,
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned ID_W   = 4,
  localparam int unsigned STRB_W = DATA_W / 8,
  localparam int unsigned A_W    = ADDR_W + ID_W + 17
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (fetch)
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [A_W-1:0]    m0_ar,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [A_W-1:0]    m0_aw,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  input  logic              m0_wlast,
  output logic              m0_bvalid,
  input  logic              m0_bready,
  output logic [1:0]        m0_bresp,
  output logic              m0_idle,
  // master 1 (load/store)
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [A_W-1:0]    m1_ar,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [A_W-1:0]    m1_aw,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic              m1_wlast,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  output logic [1:0]        m1_bresp,
  output logic              m1_idle,
  // shared slave port
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [A_W-1:0]    s_ar,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [A_W-1:0]    s_aw,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  output logic              s_wlast,
  input  logic              s_bvalid,
  output logic              s_bready,
  input  logic [1:0]        s_bresp
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ACT, W_RESP} wr_state_t;

  rd_state_t r_rd_state;
  wr_state_t r_wr_state;
  logic      r_rd_gnt;   // 1 = master 1 owns the read path
  logic      r_rd_last;
  logic      r_wr_gnt;   // 1 = master 1 owns the write path
  logic      r_wr_last;
  logic      r_aw_done;
  logic      r_w_done;

  logic w_rd_pick;
  logic w_wr_pick;
  logic w_aw_hs;
  logic w_wlast_hs;
  logic w_rd_busy;
  logic w_wr_busy;

  // Round-robin pick: alternate on contention, otherwise take the lone requester
  always_comb begin
    w_rd_pick = (m0_arvalid & m1_arvalid) ? ~r_rd_last : m1_arvalid;
    w_wr_pick = (m0_awvalid & m1_awvalid) ? ~r_wr_last : m1_awvalid;
  end

  // Read-path FSM: arbitrate, forward AR, then stream R until the last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rd_gnt   <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (m0_arvalid | m1_arvalid) begin
            r_rd_gnt   <= w_rd_pick;
            r_rd_last  <= w_rd_pick;
            r_rd_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (s_arvalid & s_arready) r_rd_state <= R_DATA;
        end
        R_DATA: begin
          if (s_rvalid & s_rready & s_rlast) r_rd_state <= R_IDLE;
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // Write-path handshake events seen on the slave side
  always_comb begin
    w_aw_hs    = s_awvalid & s_awready;
    w_wlast_hs = s_wvalid & s_wready & s_wlast;
  end

  // Write-path FSM: AW and W proceed independently, then wait for B
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_wr_gnt   <= 1'b0;
      r_wr_last  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (m0_awvalid | m1_awvalid) begin
            r_wr_gnt   <= w_wr_pick;
            r_wr_last  <= w_wr_pick;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_state <= W_ACT;
          end
        end
        W_ACT: begin
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_wlast_hs)) begin
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_state <= W_RESP;
          end else begin
            r_aw_done <= r_aw_done | w_aw_hs;
            r_w_done  <= r_w_done | w_wlast_hs;
          end
        end
        W_RESP: begin
          if (s_bvalid & s_bready) r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Read-path routing from the locked grant; everything else held at zero
  always_comb begin
    s_arvalid  = 1'b0;
    s_ar       = '0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = 2'b00;
    m0_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = 2'b00;
    m1_rlast   = 1'b0;
    if (r_rd_state == R_ADDR) begin
      if (r_rd_gnt) begin
        s_arvalid  = m1_arvalid;
        s_ar       = m1_ar;
        m1_arready = s_arready;
      end else begin
        s_arvalid  = m0_arvalid;
        s_ar       = m0_ar;
        m0_arready = s_arready;
      end
    end
    if (r_rd_state == R_DATA) begin
      if (r_rd_gnt) begin
        s_rready  = m1_rready;
        m1_rvalid = s_rvalid;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        m1_rlast  = s_rlast;
      end else begin
        s_rready  = m0_rready;
        m0_rvalid = s_rvalid;
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        m0_rlast  = s_rlast;
      end
    end
  end

  // Write-path routing; AW and W valid/ready gated once their phase is done
  always_comb begin
    s_awvalid  = 1'b0;
    s_aw       = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wlast    = 1'b0;
    s_bready   = 1'b0;
    m0_awready = 1'b0;
    m1_awready = 1'b0;
    m0_wready  = 1'b0;
    m1_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m0_bresp   = 2'b00;
    m1_bvalid  = 1'b0;
    m1_bresp   = 2'b00;
    if (r_wr_state == W_ACT) begin
      if (r_wr_gnt) begin
        s_awvalid  = m1_awvalid & ~r_aw_done;
        s_aw       = m1_aw;
        m1_awready = s_awready & ~r_aw_done;
        s_wvalid   = m1_wvalid & ~r_w_done;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wlast    = m1_wlast;
        m1_wready  = s_wready & ~r_w_done;
      end else begin
        s_awvalid  = m0_awvalid & ~r_aw_done;
        s_aw       = m0_aw;
        m0_awready = s_awready & ~r_aw_done;
        s_wvalid   = m0_wvalid & ~r_w_done;
        s_wdata    = m0_wdata;
        s_wstrb    = m0_wstrb;
        s_wlast    = m0_wlast;
        m0_wready  = s_wready & ~r_w_done;
      end
    end
    if (r_wr_state == W_RESP) begin
      if (r_wr_gnt) begin
        s_bready  = m1_bready;
        m1_bvalid = s_bvalid;
        m1_bresp  = s_bresp;
      end else begin
        s_bready  = m0_bready;
        m0_bvalid = s_bvalid;
        m0_bresp  = s_bresp;
      end
    end
  end

  // Per-master idle decode from the registered path states
  always_comb begin
    w_rd_busy = (r_rd_state != R_IDLE);
    w_wr_busy = (r_wr_state != W_IDLE);
    m0_idle   = ~((w_rd_busy & ~r_rd_gnt) | (w_wr_busy & ~r_wr_gnt));
    m1_idle   = ~((w_rd_busy &  r_rd_gnt) | (w_wr_busy &  r_wr_gnt));
  end

endmodule

// File: tb/tb_axi_arbiter_2m1s.sv
// Bench for axi_arbiter_2m1s: directed master/slave traffic, a transaction-level
// ownership model checked every cycle, and literal expectations per scenario.
module tb_axi_arbiter_2m1s;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned A_W    = ADDR_W + ID_W + 17;
  localparam int          LIM    = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              m_arvalid[2], m_arready[2], m_rvalid[2], m_rready[2], m_rlast[2];
  logic [A_W-1:0]    m_ar[2], m_aw[2];
  logic [DATA_W-1:0] m_rdata[2], m_wdata[2];
  logic [1:0]        m_rresp[2], m_bresp[2];
  logic              m_awvalid[2], m_awready[2], m_wvalid[2], m_wready[2], m_wlast[2];
  logic [STRB_W-1:0] m_wstrb[2];
  logic              m_bvalid[2], m_bready[2], m_idle[2];

  logic              s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [A_W-1:0]    s_ar, s_aw;
  logic [DATA_W-1:0] s_rdata, s_wdata;
  logic [1:0]        s_rresp, s_bresp;
  logic              s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_bvalid, s_bready;

  int n_vec = 0;
  int n_bad = 0;
  int cyc_n = 0;
  bit chk_en = 1'b0;

  // Scenario logs filled by the monitors
  int                ar_order[$];
  logic [DATA_W:0]   rx0_q[$];
  int                wev_q[$];
  logic [DATA_W-1:0] sw_q[$];
  logic [1:0]        b_got[2];

  axi_arbiter_2m1s dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]), .m0_ar(m_ar[0]),
    .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]), .m0_rdata(m_rdata[0]),
    .m0_rresp(m_rresp[0]), .m0_rlast(m_rlast[0]),
    .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]), .m0_aw(m_aw[0]),
    .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]), .m0_wdata(m_wdata[0]),
    .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]),
    .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]), .m0_bresp(m_bresp[0]),
    .m0_idle(m_idle[0]),
    .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]), .m1_ar(m_ar[1]),
    .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]), .m1_rdata(m_rdata[1]),
    .m1_rresp(m_rresp[1]), .m1_rlast(m_rlast[1]),
    .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]), .m1_aw(m_aw[1]),
    .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]), .m1_wdata(m_wdata[1]),
    .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]),
    .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]), .m1_bresp(m_bresp[1]),
    .m1_idle(m_idle[1]),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL timeout %s @%0t: got no handshake expected one within %0d cycles", name, $time, LIM);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [A_W-1:0] mk_a(input logic [63:0] addr, input logic [3:0] id,
                                         input logic [7:0] len);
    return {addr, id, len, 3'd3, 2'd1, 4'd0};
  endfunction

  // ---------------- transaction-level ownership model ----------------
  int r_own = -1, r_prev = 0, w_own = -1, w_prev = 0;
  bit r_adone = 1'b0, w_aok = 1'b0, w_wok = 1'b0, w_resp = 1'b0;

  always @(posedge clk) begin
    bit a_ok, d_ok;
    if (rst) begin
      r_own = -1; r_prev = 0; r_adone = 1'b0;
      w_own = -1; w_prev = 0; w_aok = 1'b0; w_wok = 1'b0; w_resp = 1'b0;
    end else begin
      if (r_own < 0) begin
        if (m_arvalid[0] || m_arvalid[1]) begin
          r_own   = (m_arvalid[0] && m_arvalid[1]) ? 1 - r_prev : (m_arvalid[1] ? 1 : 0);
          r_prev  = r_own;
          r_adone = 1'b0;
        end
      end else if (!r_adone) begin
        if (m_arvalid[r_own] && s_arready) r_adone = 1'b1;
      end else if (s_rvalid && m_rready[r_own] && s_rlast) begin
        r_own = -1;
      end
      if (w_own < 0) begin
        if (m_awvalid[0] || m_awvalid[1]) begin
          w_own  = (m_awvalid[0] && m_awvalid[1]) ? 1 - w_prev : (m_awvalid[1] ? 1 : 0);
          w_prev = w_own;
          w_aok = 1'b0; w_wok = 1'b0; w_resp = 1'b0;
        end
      end else if (!w_resp) begin
        a_ok = w_aok || (m_awvalid[w_own] && s_awready);
        d_ok = w_wok || (m_wvalid[w_own] && s_wready && m_wlast[w_own]);
        if (a_ok && d_ok) begin
          w_resp = 1'b1; w_aok = 1'b0; w_wok = 1'b0;
        end else begin
          w_aok = a_ok; w_wok = d_ok;
        end
      end else if (s_bvalid && m_bready[w_own]) begin
        w_own = -1; w_resp = 1'b0;
      end
    end
  end

  // Every-cycle compare of all DUT outputs against the model
  always @(negedge clk) begin
    logic              e_sarv, e_srr, e_sawv, e_swv, e_sbr;
    logic [A_W-1:0]    e_sar, e_saw;
    logic [1:0]        e_arr, e_rv, e_rl, e_awr, e_wr, e_bv, e_idle;
    logic [DATA_W-1:0] e_rd[2];
    logic [1:0]        e_rr[2], e_br[2];
    logic [DATA_W+STRB_W:0] e_sw;
    if (chk_en) begin
      e_sarv = 1'b0; e_srr = 1'b0; e_sawv = 1'b0; e_swv = 1'b0; e_sbr = 1'b0;
      e_sar = '0; e_saw = '0; e_sw = '0;
      e_arr = 2'b00; e_rv = 2'b00; e_rl = 2'b00; e_awr = 2'b00; e_wr = 2'b00; e_bv = 2'b00;
      for (int i = 0; i < 2; i++) begin
        e_rd[i] = '0; e_rr[i] = 2'b00; e_br[i] = 2'b00;
        e_idle[i] = (r_own != i) && (w_own != i);
      end
      if (r_own >= 0 && !r_adone) begin
        e_sarv = m_arvalid[r_own];
        e_sar  = m_ar[r_own];
        e_arr[r_own] = s_arready;
      end
      if (r_own >= 0 && r_adone) begin
        e_srr = m_rready[r_own];
        e_rv[r_own] = s_rvalid;
        e_rl[r_own] = s_rlast;
        e_rd[r_own] = s_rdata;
        e_rr[r_own] = s_rresp;
      end
      if (w_own >= 0 && !w_resp) begin
        e_sawv = m_awvalid[w_own] && !w_aok;
        e_saw  = m_aw[w_own];
        e_awr[w_own] = s_awready && !w_aok;
        e_swv = m_wvalid[w_own] && !w_wok;
        e_sw  = {m_wlast[w_own], m_wstrb[w_own], m_wdata[w_own]};
        e_wr[w_own] = s_wready && !w_wok;
      end
      if (w_own >= 0 && w_resp) begin
        e_sbr = m_bready[w_own];
        e_bv[w_own] = s_bvalid;
        e_br[w_own] = s_bresp;
      end
      chk("ar_fwd", 128'({s_arvalid, s_ar}), 128'({e_sarv, e_sar}));
      chk("ar_rdy", 128'({m_arready[1], m_arready[0], s_rready}), 128'({e_arr, e_srr}));
      chk("r_m0", 128'({m_rvalid[0], m_rlast[0], m_rresp[0], m_rdata[0]}),
          128'({e_rv[0], e_rl[0], e_rr[0], e_rd[0]}));
      chk("r_m1", 128'({m_rvalid[1], m_rlast[1], m_rresp[1], m_rdata[1]}),
          128'({e_rv[1], e_rl[1], e_rr[1], e_rd[1]}));
      chk("aw_fwd", 128'({s_awvalid, s_aw}), 128'({e_sawv, e_saw}));
      chk("w_fwd", 128'({s_wvalid, s_wlast, s_wstrb, s_wdata}), 128'({e_swv, e_sw}));
      chk("w_rdy", 128'({m_awready[1], m_awready[0], m_wready[1], m_wready[0], s_bready}),
          128'({e_awr, e_wr, e_sbr}));
      chk("b_m0", 128'({m_bvalid[0], m_bresp[0]}), 128'({e_bv[0], e_br[0]}));
      chk("b_m1", 128'({m_bvalid[1], m_bresp[1]}), 128'({e_bv[1], e_br[1]}));
      chk("idle", 128'({m_idle[1], m_idle[0]}), 128'(e_idle));
    end
  end

  // Handshake monitors feeding the scenario logs
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int i = 0; i < 2; i++)
        if (m_arvalid[i] && m_arready[i]) ar_order.push_back(i);
      if (m_rvalid[0] && m_rready[0]) rx0_q.push_back({m_rlast[0], m_rdata[0]});
      if (s_wvalid && s_wready) begin
        wev_q.push_back(0);
        sw_q.push_back(s_wdata);
      end
      if (s_awvalid && s_awready) wev_q.push_back(1);
    end
  end

  // ---------------- master-side drivers ----------------
  task automatic mread(input int m, input logic [63:0] addr, input logic [7:0] len,
                       input int stall_beat, input int stall_n, output int cyc);
    int start, lim, beats;
    bit hs, last, done;
    start = cyc_n;
    m_ar[m] = mk_a(addr, 4'(m + 1), len);
    m_arvalid[m] = 1'b1;
    m_rready[m]  = 1'b1;
    done = 1'b0; lim = 0;
    while (!done && lim < LIM) begin
      @(negedge clk);
      hs = m_arvalid[m] && m_arready[m];
      step();
      lim++;
      if (hs) done = 1'b1;
    end
    if (!done) timeout("mread_ar");
    m_arvalid[m] = 1'b0;
    m_ar[m] = '0;
    done = 1'b0; lim = 0; beats = 0;
    while (!done && lim < LIM) begin
      if (beats == stall_beat && stall_n > 0) begin
        m_rready[m] = 1'b0;
        repeat (stall_n) step();
        m_rready[m] = 1'b1;
        stall_n = 0;
      end
      @(negedge clk);
      hs = m_rvalid[m] && m_rready[m];
      last = m_rlast[m];
      step();
      lim++;
      if (hs) begin
        beats++;
        if (last) done = 1'b1;
      end
    end
    if (!done) timeout("mread_r");
    m_rready[m] = 1'b0;
    cyc = cyc_n - start;
  endtask

  task automatic mwrite(input int m, input logic [63:0] addr, input logic [7:0] len,
                        input logic [DATA_W-1:0] base, output int cyc);
    int start, lim;
    bit hs, done;
    start = cyc_n;
    m_aw[m] = mk_a(addr, 4'(m + 1), len);
    m_awvalid[m] = 1'b1;
    m_bready[m]  = 1'b1;
    fork
      begin
        bit ahs, adone;
        int alim;
        adone = 1'b0; alim = 0;
        while (!adone && alim < LIM) begin
          @(negedge clk);
          ahs = m_awvalid[m] && m_awready[m];
          step();
          alim++;
          if (ahs) adone = 1'b1;
        end
        if (!adone) timeout("mwrite_aw");
        m_awvalid[m] = 1'b0;
      end
      begin
        bit whs;
        int wlim;
        for (int b = 0; b <= int'(len); b++) begin
          m_wvalid[m] = 1'b1;
          m_wdata[m]  = base + DATA_W'(b);
          m_wstrb[m]  = '1;
          m_wlast[m]  = (b == int'(len));
          whs = 1'b0; wlim = 0;
          while (!whs && wlim < LIM) begin
            @(negedge clk);
            whs = m_wvalid[m] && m_wready[m];
            step();
            wlim++;
          end
          if (!whs) timeout("mwrite_w");
        end
        m_wvalid[m] = 1'b0;
        m_wlast[m]  = 1'b0;
      end
    join
    done = 1'b0; lim = 0;
    while (!done && lim < LIM) begin
      @(negedge clk);
      hs = m_bvalid[m] && m_bready[m];
      if (hs) b_got[m] = m_bresp[m];
      step();
      lim++;
      if (hs) done = 1'b1;
    end
    if (!done) timeout("mwrite_b");
    m_bready[m] = 1'b0;
    cyc = cyc_n - start;
  endtask

  // ---------------- slave-side responders ----------------
  task automatic sread(input int n_txn, input logic [DATA_W-1:0] base);
    int lim;
    bit hs;
    logic [A_W-1:0] a;
    int len;
    for (int t = 0; t < n_txn; t++) begin
      s_arready = 1'b1;
      hs = 1'b0; lim = 0; len = 0;
      while (!hs && lim < LIM) begin
        @(negedge clk);
        hs = s_arvalid && s_arready;
        a = s_ar;
        step();
        lim++;
      end
      if (!hs) timeout("sread_ar");
      len = int'(a[16:9]);
      s_arready = 1'b0;
      for (int b = 0; b <= len; b++) begin
        s_rvalid = 1'b1;
        s_rdata  = base + DATA_W'(t * 16 + b);
        s_rresp  = 2'b00;
        s_rlast  = (b == len);
        hs = 1'b0; lim = 0;
        while (!hs && lim < LIM) begin
          @(negedge clk);
          hs = s_rvalid && s_rready;
          step();
          lim++;
        end
        if (!hs) timeout("sread_r");
      end
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      s_rdata  = '0;
    end
  endtask

  task automatic swrite(input int aw_delay);
    int lim;
    bit hs;
    s_awready = (aw_delay == 0);
    s_wready  = 1'b1;
    fork
      begin
        bit seen, ahs;
        int alim;
        if (aw_delay > 0) begin
          seen = 1'b0; alim = 0;
          while (!seen && alim < LIM) begin
            @(negedge clk);
            seen = s_awvalid;
            step();
            alim++;
          end
          repeat (aw_delay) step();
          s_awready = 1'b1;
        end
        ahs = 1'b0; alim = 0;
        while (!ahs && alim < LIM) begin
          @(negedge clk);
          ahs = s_awvalid && s_awready;
          step();
          alim++;
        end
        if (!ahs) timeout("swrite_aw");
        s_awready = 1'b0;
      end
      begin
        bit wl;
        int wlim;
        wl = 1'b0; wlim = 0;
        while (!wl && wlim < LIM) begin
          @(negedge clk);
          wl = s_wvalid && s_wready && s_wlast;
          step();
          wlim++;
        end
        if (!wl) timeout("swrite_w");
        s_wready = 1'b0;
      end
    join
    s_bvalid = 1'b1;
    s_bresp  = 2'b00;
    hs = 1'b0; lim = 0;
    while (!hs && lim < LIM) begin
      @(negedge clk);
      hs = s_bvalid && s_bready;
      step();
      lim++;
    end
    if (!hs) timeout("swrite_b");
    s_bvalid = 1'b0;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      m_arvalid[i] = 1'b0; m_ar[i] = '0; m_rready[i] = 1'b0;
      m_awvalid[i] = 1'b0; m_aw[i] = '0; m_wvalid[i] = 1'b0;
      m_wdata[i] = '0; m_wstrb[i] = '0; m_wlast[i] = 1'b0; m_bready[i] = 1'b0;
    end
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int c_rd, c_wr, dummy;
    clear_inputs();
    b_got[0] = 2'b11;
    b_got[1] = 2'b11;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_state", 128'({m_idle[1], m_idle[0], s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}),
        128'(7'b1100000));

    // 1: single m0 read, granted one cycle after arvalid
    m_ar[0] = mk_a(64'h8000_0000, 4'd1, 8'd0);
    m_arvalid[0] = 1'b1;
    m_rready[0]  = 1'b1;
    s_arready    = 1'b1;
    step();
    chk("t1_ar_issue", 128'({s_arvalid, m_arready[0], m_arready[1], m_idle[0]}), 128'(4'b1100));
    chk("t1_ar_addr", 128'(s_ar[A_W-1:21]), 128'(64'h8000_0000));
    step();
    m_arvalid[0] = 1'b0;
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    s_rlast   = 1'b1;
    s_rdata   = 64'hA5A5_0000_1234_5678;
    #1;
    chk("t1_r_beat", 128'({m_rvalid[0], m_rlast[0], m_rdata[0]}), 128'({2'b11, 64'hA5A5_0000_1234_5678}));
    chk("t1_m1_quiet", 128'(m_rvalid[1]), 128'(1'b0));
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; m_rready[0] = 1'b0;
    #1;
    chk("t1_idle_back", 128'(m_idle[0]), 128'(1'b1));
    step();

    // 2: simultaneous requests alternate, m1 first
    ar_order.delete();
    fork
      begin repeat (4) mread(0, 64'h100, 8'd1, -1, 0, dummy); end
      begin repeat (4) mread(1, 64'h200, 8'd0, -1, 0, dummy); end
      sread(8, 64'h2000);
    join
    chk("t2_count", 128'(ar_order.size()), 128'(8));
    for (int i = 0; i < 8 && i < ar_order.size(); i++)
      chk("t2_order", 128'(ar_order[i]), 128'((i % 2 == 0) ? 1 : 0));
    step();

    // 3: m1 write, W ahead of a late AW
    wev_q.delete();
    sw_q.delete();
    b_got[1] = 2'b11;
    fork
      mwrite(1, 64'h3000, 8'd3, 64'hD000, dummy);
      swrite(5);
    join
    chk("t3_events", 128'(wev_q.size()), 128'(5));
    for (int i = 0; i < 5 && i < wev_q.size(); i++)
      chk("t3_order", 128'(wev_q[i]), 128'((i == 4) ? 1 : 0));
    for (int i = 0; i < 4 && i < sw_q.size(); i++)
      chk("t3_wdata", 128'(sw_q[i]), 128'(64'hD000 + 64'(i)));
    chk("t3_bresp", 128'(b_got[1]), 128'(2'b00));
    step();

    // 4: m0 back-pressure mid-burst
    rx0_q.delete();
    fork
      mread(0, 64'h4000, 8'd3, 1, 3, dummy);
      sread(1, 64'h4400);
    join
    chk("t4_beats", 128'(rx0_q.size()), 128'(4));
    for (int i = 0; i < 4 && i < rx0_q.size(); i++)
      chk("t4_beat", 128'(rx0_q[i]), 128'({(i == 3), 64'h4400 + 64'(i)}));
    step();

    // 5: concurrent m0 read and m1 write keep their solo latency
    fork
      mread(0, 64'h5000, 8'd1, -1, 0, c_rd);
      sread(1, 64'h5500);
      mwrite(1, 64'h6000, 8'd0, 64'hE000, c_wr);
      swrite(0);
    join
    chk("t5_rd_cycles", 128'(c_rd), 128'(4));
    chk("t5_wr_cycles", 128'(c_wr), 128'(3));
    step();

    // 6: reset while read is in R_DATA and write in W_ACT
    m_ar[0] = mk_a(64'h7000, 4'd1, 8'd3);
    m_arvalid[0] = 1'b1;
    s_arready = 1'b1;
    m_aw[1] = mk_a(64'h7800, 4'd2, 8'd1);
    m_awvalid[1] = 1'b1;
    step();
    step();
    m_arvalid[0] = 1'b0;
    s_arready = 1'b0;
    s_rvalid = 1'b1;
    #1;
    chk("t6_busy", 128'({m_idle[1], m_idle[0], m_rvalid[0], s_awvalid}), 128'(4'b0011));
    rst = 1'b1;
    clear_inputs();
    step();
    chk("t6_after_rst", 128'({s_arvalid, s_awvalid, s_wvalid, m_rvalid[0], m_rvalid[1],
                              m_bvalid[0], m_bvalid[1], m_idle[1], m_idle[0]}), 128'(9'b000000011));
    rst = 1'b0;
    step();
    fork
      mread(1, 64'h7100, 8'd0, -1, 0, c_rd);
      sread(1, 64'h7700);
    join
    chk("t6_rd_cycles", 128'(c_rd), 128'(3));
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run expected one before 2 ms");
    $fatal(1);
  end

endmodule
